// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative RV32M multiply/divide unit.
// Optional build macro used by ex_muldiv_unit: MULDIV_EARLY_OUT_EN.
package muldiv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] MD_DIV0_Q = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] MD_OVF_Q  = 32'h8000_0000;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ITER    = 2'd1,
        SPECIAL = 2'd2,
        DONE    = 2'd3
    } md_state_e;

    function automatic logic md_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    // MUL is treated as signed x signed; its low word is identical either way.
    function automatic logic md_signed_a(input logic [2:0] op);
        return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
               (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic md_signed_b(input logic [2:0] op);
        return (op == MD_MUL) || (op == MD_MULH) ||
               (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/muldiv_sign_fixup.sv
// Final sign correction and word selection for the multiply/divide unit.
// Turns the unsigned-magnitude accumulator into the architectural result word.
module muldiv_sign_fixup
    import muldiv_pkg::*;
(
    input  logic [2:0]        i_op,
    input  logic              i_neg_a,
    input  logic              i_neg_b,
    input  logic              i_div0,
    input  logic              i_ovf,
    input  logic [2*XLEN-1:0] i_acc,
    output logic [XLEN-1:0]   o_result
);

    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;
    logic              w_neg_res;

    // For divides the accumulator holds {remainder, quotient}; for multiplies the product.
    always_comb begin
        w_neg_res = i_neg_a ^ i_neg_b;
        w_prod    = w_neg_res ? -i_acc : i_acc;
        w_quot    = w_neg_res ? -i_acc[XLEN-1:0] : i_acc[XLEN-1:0];
        w_rem     = i_neg_a ? -i_acc[2*XLEN-1:XLEN] : i_acc[2*XLEN-1:XLEN];

        if (i_div0) begin
            w_quot = MD_DIV0_Q;
        end
        if (i_ovf) begin
            w_quot = MD_OVF_Q;
            w_rem  = '0;
        end

        if (!md_is_div(i_op)) begin
            o_result = (i_op == MD_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
        end else begin
            o_result = i_op[1] ? w_rem : w_quot;
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide execute unit; stalls the front end while busy.
// Optional build macro: MULDIV_EARLY_OUT_EN (multiplies finish once the multiplier is exhausted).
module ex_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            stall_req,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    import muldiv_pkg::md_state_e;
    import muldiv_pkg::IDLE;
    import muldiv_pkg::ITER;
    import muldiv_pkg::SPECIAL;
    import muldiv_pkg::DONE;
    import muldiv_pkg::md_is_div;
    import muldiv_pkg::md_signed_a;
    import muldiv_pkg::md_signed_b;

    localparam int ACC_W = 2 * XLEN;

    md_state_e          r_state;
    md_state_e          w_state_next;
    logic               w_accept;

    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_op;
    logic [4:0]         r_rd;
    logic               r_neg_a;
    logic               r_neg_b;
    logic               r_div0;
    logic               r_ovf;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   r_mcand;
    logic [XLEN-1:0]    r_opb;

    logic               r_result_valid;
    logic [XLEN-1:0]    r_result;
    logic [4:0]         r_rd_out;

    logic               w_neg_a;
    logic               w_neg_b;
    logic [XLEN-1:0]    w_mag_a;
    logic [XLEN-1:0]    w_mag_b;
    logic               w_div0;
    logic               w_ovf;
    logic               w_early_out;

    logic [ACC_W-1:0]   w_mul_acc;
    logic [XLEN:0]      w_rem_sh;
    logic [XLEN:0]      w_diff;
    logic               w_ge;
    logic [ACC_W-1:0]   w_div_acc;
    logic [ACC_W-1:0]   w_acc_step;
    logic [ACC_W-1:0]   w_acc_final;
    logic [XLEN-1:0]    w_fix_result;

    // Operand decode for the incoming EX-stage instruction.
    assign w_neg_a = md_signed_a(op) & rs1_val[XLEN-1];
    assign w_neg_b = md_signed_b(op) & rs2_val[XLEN-1];
    assign w_mag_a = w_neg_a ? -rs1_val : rs1_val;
    assign w_mag_b = w_neg_b ? -rs2_val : rs2_val;
    assign w_div0  = md_is_div(op) & (rs2_val == '0);
    assign w_ovf   = md_is_div(op) & ~op[0] &
                     (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) & (rs2_val == '1);

`ifdef MULDIV_EARLY_OUT_EN
    assign w_early_out = ~md_is_div(r_op) & (r_opb == '0);
`else
    assign w_early_out = 1'b0;
`endif

    // One shift-add multiply step: the multiplicand walks left, the multiplier right.
    assign w_mul_acc = r_acc + (r_opb[0] ? r_mcand : {ACC_W{1'b0}});

    // One restoring divide step on {remainder, dividend/quotient}.
    assign w_rem_sh  = {r_acc[ACC_W-1:XLEN], r_acc[XLEN-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_opb};
    assign w_ge      = ~w_diff[XLEN];
    assign w_div_acc = {(w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0]),
                        r_acc[XLEN-2:0], w_ge};

    assign w_acc_step  = md_is_div(r_op) ? w_div_acc : w_mul_acc;
    assign w_acc_final = (r_state == ITER) ? w_acc_step : r_acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !flush) begin
                    w_accept     = 1'b1;
                    w_state_next = (w_div0 || w_ovf) ? SPECIAL : ITER;
                end
            end
            ITER: begin
                if (flush) begin
                    w_state_next = IDLE;
                end else if ((r_cnt == CNT_W'(XLEN - 1)) || w_early_out) begin
                    w_state_next = DONE;
                end
            end
            SPECIAL: begin
                w_state_next = flush ? IDLE : DONE;
            end
            DONE: begin
                // The finished instruction has already left EX, so flush cannot kill it.
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_op    <= '0;
            r_rd    <= '0;
            r_neg_a <= 1'b0;
            r_neg_b <= 1'b0;
            r_div0  <= 1'b0;
            r_ovf   <= 1'b0;
            r_acc   <= '0;
            r_mcand <= '0;
            r_opb   <= '0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_op    <= op;
            r_rd    <= rd_in;
            r_neg_a <= w_neg_a;
            r_neg_b <= w_neg_b;
            r_div0  <= w_div0;
            r_ovf   <= w_ovf;
            r_mcand <= {{XLEN{1'b0}}, w_mag_a};
            r_opb   <= w_mag_b;
            // A divide by zero parks |rs1| in the remainder half so the fixup yields rs1.
            if (!md_is_div(op)) begin
                r_acc <= '0;
            end else if (w_div0) begin
                r_acc <= {w_mag_a, {XLEN{1'b0}}};
            end else begin
                r_acc <= {{XLEN{1'b0}}, w_mag_a};
            end
        end else if (r_state == ITER) begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_acc <= w_acc_step;
            if (!md_is_div(r_op)) begin
                r_mcand <= r_mcand << 1;
                r_opb   <= r_opb >> 1;
            end
        end
    end

    muldiv_sign_fixup u_fixup (
        .i_op     (r_op),
        .i_neg_a  (r_neg_a),
        .i_neg_b  (r_neg_b),
        .i_div0   (r_div0),
        .i_ovf    (r_ovf),
        .i_acc    (w_acc_final),
        .o_result (w_fix_result)
    );

    // Result is captured on the edge entering DONE and then held until the next op.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result_valid <= 1'b0;
            r_result       <= '0;
            r_rd_out       <= '0;
        end else begin
            r_result_valid <= (w_state_next == DONE);
            if (w_state_next == DONE) begin
                r_result <= w_fix_result;
                r_rd_out <= r_rd;
            end
        end
    end

    assign stall_req    = ((r_state == IDLE) & start & ~flush) |
                          (r_state == ITER) | (r_state == SPECIAL);
    assign busy         = (r_state != IDLE);
    assign result_valid = r_result_valid;
    assign result       = r_result;
    assign rd_out       = r_rd_out;

endmodule
